// File: rtl/gshare_branch_predictor.sv
// Two-level gshare branch predictor: global history plus a flop-array PHT of saturating counters.
// Predicts for the branch in ID, trains on the branch resolved in EX, and keeps saturating statistics.
module gshare_branch_predictor #(
    parameter int HIST_BITS  = 4,
    parameter int CTR_BITS   = 2,
    parameter int CTR_INIT   = 1,
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_MODE = 1,
    parameter int BYPASS     = 0,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BranchInstructExists_ID,
    input  logic [PC_WIDTH-1:0]   PC_ID,
    output logic                  Prediction,
    output logic [HIST_BITS-1:0]  PredIndex_ID,
    input  logic                  BranchInstructExists_EX,
    input  logic                  BranchDecision_EX,
    input  logic [HIST_BITS-1:0]  PredIndex_EX,
    input  logic                  PredictedTaken_EX,
    output logic                  Mispredict_EX,
    output logic [STAT_WIDTH-1:0] BranchCount,
    output logic [STAT_WIDTH-1:0] MispredictCount
);

    localparam int                  PHT_DEPTH = 1 << HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'(CTR_INIT);
    localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;

    function automatic logic [CTR_BITS-1:0] ctr_train(input logic [CTR_BITS-1:0] ctr,
                                                      input logic               taken);
        logic [CTR_BITS-1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) res = ctr + CTR_BITS'(1);
        end else begin
            if (ctr != '0) res = ctr - CTR_BITS'(1);
        end
        return res;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] cnt,
                                                       input logic                  en);
        logic [STAT_WIDTH-1:0] res;
        res = cnt;
        if (en && (cnt != '1)) res = cnt + STAT_WIDTH'(1);
        return res;
    endfunction

    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic [CTR_BITS-1:0]   pht_q [PHT_DEPTH];
    logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [CTR_BITS-1:0]   ctr_upd;
    logic [HIST_BITS-1:0]  ghr_rd;
    logic [HIST_BITS-1:0]  rd_idx;
    logic                  fwd_hit;
    logic [CTR_BITS-1:0]   ctr_rd;
    logic                  mispredict;
    logic                  unused_pc;

    assign mispredict    = BranchInstructExists_EX & (BranchDecision_EX != PredictedTaken_EX);
    assign Mispredict_EX = mispredict;

    // Training always targets the index carried from ID, never a recomputed one.
    always_comb begin
        ghr_d   = ghr_q;
        ctr_upd = ctr_train(pht_q[PredIndex_EX], BranchDecision_EX);
        if (BranchInstructExists_EX) begin
            ghr_d = {ghr_q[HIST_BITS-2:0], BranchDecision_EX};
        end
        branch_cnt_d  = stat_inc(branch_cnt_q, BranchInstructExists_EX);
        mispred_cnt_d = stat_inc(mispred_cnt_q, mispredict);
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            assign ghr_rd  = ghr_d;
            assign fwd_hit = BranchInstructExists_EX && (rd_idx == PredIndex_EX);
        end else begin : g_no_bypass
            assign ghr_rd  = ghr_q;
            assign fwd_hit = 1'b0;
        end

        if (INDEX_MODE != 0) begin : g_gshare
            assign rd_idx = ghr_rd ^ PC_ID[HIST_BITS+1:2];
        end else begin : g_hist_only
            assign rd_idx = ghr_rd;
        end
    endgenerate

    // Only a slice of the PC feeds the index; the rest is deliberately ignored.
    assign unused_pc = ^PC_ID;

    assign ctr_rd       = fwd_hit ? ctr_upd : pht_q[rd_idx];
    assign PredIndex_ID = rd_idx;
    assign Prediction   = BranchInstructExists_ID & ctr_rd[CTR_BITS-1];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CTR_RST;
            end
        end else begin
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (BranchInstructExists_EX) begin
                pht_q[PredIndex_EX] <= ctr_upd;
            end
        end
    end

    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mispred_cnt_q;

endmodule
